// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-side memory responder:
// MMIO register offsets, the address region enum and CONS_STAT bit placement.
package dmem_pkg;

  localparam logic [7:0] OFF_HALT      = 8'h00;
  localparam logic [7:0] OFF_CYCLE_LO  = 8'h04;
  localparam logic [7:0] OFF_CYCLE_HI  = 8'h08;
  localparam logic [7:0] OFF_CONS_TX   = 8'h0C;
  localparam logic [7:0] OFF_CONS_STAT = 8'h10;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // Flag positions in CONS_STAT, counted upward from the first bit above the count field.
  localparam int STAT_EMPTY_OFS = 0;
  localparam int STAT_FULL_OFS  = 1;
  localparam int STAT_OVF_OFS   = 2;

endpackage

// File: rtl/data_mem_responder_console_fifo.sv
// Synchronous byte FIFO behind the console TX register; a push while full
// is dropped and latches a sticky overflow flag unless a pop frees the slot.
module console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop_req,
  output logic [7:0]               head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop;
  logic          push_ok;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign pop       = pop_req && !empty;
  assign push_ok   = push && (!full || pop);
  assign head_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly PW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push && !push_ok)     overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side responder for the CPU: byte-enabled word RAM plus an MMIO window
// with halt/exit code, a 64-bit cycle counter and a console byte FIFO.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DATA_MEM_SIZE = 1024,
  parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
  parameter int          FIFO_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_we_i,
  output logic [31:0] data_rdata_o,
  output logic [7:0]  cons_data_o,
  output logic        cons_valid_o,
  input  logic        cons_ready_i,
  output logic        halt_o,
  output logic [7:0]  exit_code_o,
  output logic        bus_err_o
);

  localparam int          AW        = $clog2(DATA_MEM_SIZE);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DATA_MEM_SIZE * 4);

  region_e       region;
  logic [7:0]    mmio_off;
  logic          wr;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram [DATA_MEM_SIZE];
  logic [63:0]   counter;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic [31:0]   stat_word;

  assign wr       = (data_we_i != 4'b0000);
  assign mmio_off = {data_addr_i[7:2], 2'b00};
  assign ram_idx  = data_addr_i[AW+1:2];

  always_comb begin
    region = REG_NONE;
    if (data_addr_i < RAM_BYTES)                      region = REG_RAM;
    else if (data_addr_i[31:8] == MMIO_BASE[31:8])    region = REG_MMIO;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr && region == REG_RAM) begin
      for (int k = 0; k < 4; k++) begin
        if (data_we_i[k]) ram[ram_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
      end
    end
  end

  // Counter samples the registered halt, so the cycle carrying the HALT write still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= '0;
      halt_o      <= 1'b0;
      exit_code_o <= 8'h00;
      bus_err_o   <= 1'b0;
    end else begin
      if (!halt_o) counter <= counter + 64'd1;
      if (wr && region == REG_MMIO && mmio_off == OFF_HALT && !halt_o) begin
        halt_o      <= 1'b1;
        exit_code_o <= data_wdata_i[7:0];
      end
      if (wr && region == REG_NONE) bus_err_o <= 1'b1;
    end
  end

  assign fifo_push = !rst && wr && region == REG_MMIO && mmio_off == OFF_CONS_TX;

  console_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(data_wdata_i[7:0]),
    .pop_req  (cons_ready_i),
    .head_data(cons_data_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  assign cons_valid_o = !fifo_empty;

  always_comb begin
    stat_word                      = '0;
    stat_word[CW-1:0]              = fifo_count;
    stat_word[CW + STAT_EMPTY_OFS] = fifo_empty;
    stat_word[CW + STAT_FULL_OFS]  = fifo_full;
    stat_word[CW + STAT_OVF_OFS]   = fifo_ovf;
  end

  always_comb begin
    data_rdata_o = '0;
    if (region == REG_RAM) begin
      data_rdata_o = ram[ram_idx];
    end else if (region == REG_MMIO) begin
      case (mmio_off)
        OFF_HALT:      data_rdata_o = {23'b0, halt_o, exit_code_o};
        OFF_CYCLE_LO:  data_rdata_o = counter[31:0];
        OFF_CYCLE_HI:  data_rdata_o = counter[63:32];
        OFF_CONS_STAT: data_rdata_o = stat_word;
        default:       data_rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed and random bus traffic
// compared against a queue/array reference model of the memory map.
module tb_data_mem_responder;

  localparam int          DEPTH = 16;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] MB    = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        ready;
  logic [31:0] rdata;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        halt;
  logic [7:0]  exit_code;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram_m [int];
  bit          m_halt;
  logic [7:0]  m_code;
  bit          m_err;
  logic [63:0] m_cnt;
  logic [7:0]  m_q [$];
  bit          m_ovf;
  logic [31:0] pool [16];

  data_mem_responder #(
    .DATA_MEM_SIZE(1024),
    .MMIO_BASE    (MB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_addr_i (addr),
    .data_wdata_i(wdata),
    .data_we_i   (we),
    .data_rdata_o(rdata),
    .cons_data_o (cons_data),
    .cons_valid_o(cons_valid),
    .cons_ready_i(ready),
    .halt_o      (halt),
    .exit_code_o (exit_code),
    .bus_err_o   (bus_err)
  );

  always #5 clk = ~clk;

  function automatic int regionOf(input logic [31:0] a);
    if (a < 32'd4096) return 0;
    if (a[31:8] == MB[31:8]) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] expRead(input logic [31:0] a);
    int          sz;
    logic [7:0]  off;
    sz  = m_q.size();
    off = a[7:0] & 8'hFC;
    case (regionOf(a))
      0: return ram_m.exists(int'(a[11:2])) ? ram_m[int'(a[11:2])] : 32'h0;
      1: begin
        if (off == 8'h00) return {23'b0, m_halt, m_code};
        if (off == 8'h04) return m_cnt[31:0];
        if (off == 8'h08) return m_cnt[63:32];
        if (off == 8'h10) return 32'(sz) + (32'(sz == 0) << CW) + (32'(sz == DEPTH) << (CW + 1))
                               + (32'(m_ovf) << (CW + 2));
        return 32'h0;
      end
      default: return 32'h0;
    endcase
  endfunction

  // Advance the reference model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit          pop;
    int          idx;
    logic [31:0] w;
    logic [7:0]  off;
    if (rst) begin
      m_halt = 0; m_code = 8'h00; m_err = 0; m_cnt = 64'd0; m_ovf = 0;
      m_q.delete();
    end else begin
      pop = (m_q.size() > 0) && ready;
      off = addr[7:0] & 8'hFC;
      if (we != 4'b0000 && regionOf(addr) == 0) begin
        idx = int'(addr[11:2]);
        w   = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
        for (int k = 0; k < 4; k++) if (we[k]) w[8*k +: 8] = wdata[8*k +: 8];
        ram_m[idx] = w;
      end
      if (!m_halt) m_cnt = m_cnt + 64'd1;
      if (we != 4'b0000 && regionOf(addr) == 1 && off == 8'h00 && !m_halt) begin
        m_halt = 1; m_code = wdata[7:0];
      end
      if (pop) void'(m_q.pop_front());
      if (we != 4'b0000 && regionOf(addr) == 1 && off == 8'h0C) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
        else m_ovf = 1;
      end
      if (we != 4'b0000 && regionOf(addr) == 2) m_err = 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic checkState();
    checkOutput("halt_o", 32'(halt), 32'(m_halt));
    checkOutput("exit_code_o", 32'(exit_code), 32'(m_code));
    checkOutput("bus_err_o", 32'(bus_err), 32'(m_err));
    checkOutput("cons_valid_o", 32'(cons_valid), 32'(m_q.size() > 0));
    checkOutput("cons_data_o", 32'(cons_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
    checkState();
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
    addr = a; wdata = d; we = e;
    tick();
    we = 4'b0000;
  endtask

  task automatic doRead(input string tag, input logic [31:0] a);
    addr = a; we = 4'b0000;
    #1;
    checkOutput(tag, rdata, expRead(a));
    tick();
  endtask

  initial begin
    rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 4'b0000; ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    doRead("reset_cycle_lo", MB + 32'h04);
    doRead("reset_cycle_hi", MB + 32'h08);
    doRead("reset_stat", MB + 32'h10);

    applyStimulus(32'h100, 32'hAABBCCDD, 4'b1111);
    applyStimulus(32'h100, 32'h11223344, 4'b0101);
    addr = 32'h100; #1;
    checkOutput("lane_merge_const", rdata, 32'hAA22CC44);
    doRead("lane_merge", 32'h100);
    doRead("lane_addr_103", 32'h103);

    for (int i = 0; i < 16; i++) begin
      pool[i] = 32'($urandom_range(0, 1023)) << 2;
      applyStimulus(pool[i] | 32'($urandom_range(0, 3)), $urandom, 4'b1111);
    end
    for (int i = 0; i < 30; i++) begin
      applyStimulus(pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3)), $urandom,
                    4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++) doRead("ram_random", pool[i]);
    doRead("cycle_lo_run", MB + 32'h04);

    ready = 1'b0;
    applyStimulus(MB + 32'h0C, 32'h48, 4'b1111);
    applyStimulus(MB + 32'h0C, 32'h69, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("cons_hold_H", 32'(cons_data), 32'h48);
    end
    ready = 1'b1;
    tick();
    checkOutput("cons_second_i", 32'(cons_data), 32'h69);
    tick();
    checkOutput("cons_drained", 32'(cons_valid), 32'h0);

    ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(MB + 32'h0C, $urandom, 4'b1111);
    addr = MB + 32'h10; #1;
    checkOutput("stat_full_const", rdata, 32'hD0);
    doRead("stat_full", MB + 32'h10);
    ready = 1'b1;
    applyStimulus(MB + 32'h0C, 32'h5A, 4'b1111);
    doRead("stat_push_pop_full", MB + 32'h10);
    for (int i = 0; i < 40 && m_q.size() > 1; i++) tick();
    checkOutput("last_out_new", 32'(cons_data), 32'h5A);
    tick();

    for (int i = 0; i < 60; i++) begin
      addr  = $urandom_range(0, 1) ? MB + 32'h0C : MB + 32'h10;
      we    = $urandom_range(0, 2) != 0 ? 4'b1111 : 4'b0000;
      wdata = $urandom;
      ready = 1'($urandom_range(0, 1));
      #1;
      checkOutput("stat_random", rdata, expRead(addr));
      tick();
    end
    we = 4'b0000;

    applyStimulus(MB + 32'h00, 32'h5A, 4'b0001);
    applyStimulus(MB + 32'h00, 32'h33, 4'b1111);
    checkOutput("halt_code_const", 32'(exit_code), 32'h5A);
    addr = MB; #1;
    checkOutput("halt_reg_const", rdata, 32'h15A);
    doRead("cycle_lo_halted_a", MB + 32'h04);
    tick();
    tick();
    doRead("cycle_lo_halted_b", MB + 32'h04);
    applyStimulus(pool[0], 32'hCAFEF00D, 4'b1111);
    doRead("ram_after_halt", pool[0]);

    applyStimulus(32'h4000_0000, 32'h12345678, 4'b1111);
    checkOutput("bus_err_const", 32'(bus_err), 32'h1);
    doRead("unmapped_read", 32'h4000_0000);
    doRead("ram_untouched", 32'h100);
    doRead("mmio_undef", MB + 32'h20);
    doRead("cons_tx_read", MB + 32'h0C);

    ready = 1'b0;
    applyStimulus(MB + 32'h0C, 32'h41, 4'b1111);
    applyStimulus(MB + 32'h0C, 32'h42, 4'b1111);
    rst = 1'b1;
    applyStimulus(32'h100, 32'hDEADBEEF, 4'b1111);
    rst = 1'b0;
    addr = MB + 32'h10; #1;
    checkOutput("stat_after_reset_const", rdata, 32'h20);
    doRead("cycle_lo_after_reset", MB + 32'h04);
    doRead("halt_after_reset", MB + 32'h00);
    doRead("ram_retained", 32'h100);
    doRead("ram_retained_pool", pool[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-side responder for the riscv_cpu data memory interface: the CPU drives address, write data and byte write enables, and this block returns read data.
Contains:
- word-addressed RAM with byte enables;
- an MMIO window holding a halt/exit-code register, a free-running 64-bit cycle counter, and a console byte FIFO drained over a valid/ready output.
Instantiated beside the CPU in the top-level and in simulation, replacing ad-hoc memory models.

Parameters:
DATA_MEM_SIZE, 1024, RAM depth in 32-bit words; power of two.
MMIO_BASE, 32'h8000_0000, byte base of MMIO window; window is 256 bytes.
FIFO_DEPTH, 16, console FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
data_addr_i  in  32  byte address from CPU
data_wdata_i  in  32  store data, byte lanes aligned to address word
data_we_i  in  4  byte write enables; 4'b0000 = read/idle
data_rdata_o  out  32  read data, combinational from data_addr_i
cons_data_o  out  8  console byte at FIFO head
cons_valid_o  out  1  FIFO non-empty
cons_ready_i  in  1  consumer accepts head byte
halt_o  out  1  program wrote HALT
exit_code_o  out  8  latched exit code
bus_err_o  out  1  sticky: write to unmapped address

Behaviour:
- Decode:
  - RAM when data_addr_i < DATA_MEM_SIZE*4.
  - MMIO when data_addr_i[31:8] == MMIO_BASE[31:8].
  - Otherwise unmapped.
  - data_addr_i[1:0] ignored everywhere (word access with lane enables).
- Reads:
  - Combinational, side-effect free; there is no read strobe.
  - Unmapped or undefined MMIO offsets return 0.
- RAM:
  - Word index data_addr_i[$clog2(DATA_MEM_SIZE)+1:2].
  - Lane k written at posedge when data_we_i[k] is set and rst is low.
  - Contents are not cleared by reset; bench preloads with $readmemh.
  - Read of a word written in the same cycle returns old data until the edge.
- MMIO offsets (any nonzero data_we_i counts as a write):
  - 0x00 HALT
    - W: if halt_o=0, set halt_o=1 and exit_code_o=data_wdata_i[7:0] next cycle.
    - Later writes are ignored; the first code is kept.
    - R: {23'b0, halt_o, exit_code_o}.
  - 0x04 CYCLE_LO, R: counter[31:0].
  - 0x08 CYCLE_HI, R: counter[63:32].
    - Counter increments by 1 each cycle out of reset and freezes while halt_o=1.
    - Wraps modulo 2^64. Writes ignored.
  - 0x0C CONS_TX
    - W: push data_wdata_i[7:0].
    - If FIFO full and no pop this cycle: byte dropped, sticky overflow flag set.
    - R: 0.
  - 0x10 CONS_STAT, R: {overflow, full, empty, count}.
    - count in bits [$clog2(FIFO_DEPTH):0]; full/empty/overflow placed in the three bits above count.
    - Flags reflect registered state.
  - Writes to other MMIO offsets are ignored, no error.
- Unmapped write: bus_err_o set next cycle, sticky until reset. Unmapped read: no error.
- Console FIFO:
  - Pop when cons_valid_o && cons_ready_i.
  - Push and pop in the same cycle are both accepted, including when full, and count is unchanged.
  - No bypass: a push into an empty FIFO raises cons_valid_o the following cycle.
  - cons_data_o is held stable while valid && !ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (synchronous, includes reset mid-operation):
  - halt_o=0, exit_code_o=0, bus_err_o=0, counter=0.
  - FIFO emptied: cons_valid_o=0, cons_data_o=0, overflow=0.
  - All writes suppressed while rst=1.
- Halt does not block RAM or FIFO writes; the CPU's halt loop may continue issuing accesses.

Decomposition:
- Package dmem_pkg holds:
  - MMIO offset constants: OFF_HALT, OFF_CYCLE_LO, OFF_CYCLE_HI, OFF_CONS_TX, OFF_CONS_STAT;
  - a region enum: REG_RAM, REG_MMIO, REG_NONE;
  - the status bit positions.
- One sub-module, console_fifo: a synchronous byte FIFO with push, pop, full, empty, count and overflow outputs, and the same clk/rst.
- Address decode, RAM, HALT, counter and read mux stay in the top.

Test Plan:
- RAM byte lanes: write 0xAABBCCDD to 0x100 with we=4'b1111, then 0x11223344 with we=4'b0101 -> read 0x100 = 0xAA22CC44; read 0x103 returns the same word.
- Halt: after reset, write 0x5A to MMIO_BASE+0x00, then write 0x33 -> halt_o=1, exit_code_o=0x5A; CYCLE_LO read twice over 3 cycles -> identical values.
- Console order and backpressure: push 'H','i' with cons_ready_i=0 for 4 cycles -> cons_valid_o=1, cons_data_o='H' held stable; then ready=1 -> 'H','i' emitted on consecutive cycles, then valid=0.
- FIFO boundary: push FIFO_DEPTH+1 bytes with ready=0 -> STAT shows full=1, overflow=1, count=16. Push while full with ready=1 -> count stays 16, no overflow increment, new byte last out.
- Unmapped/reset: write to 0x4000_0000 -> bus_err_o=1, RAM unchanged, read returns 0. Assert rst for 1 cycle mid-stream -> all flags and the counter are 0, FIFO empty, RAM contents retained.
